// File: rtl/isqrt_pkg.sv
// Shared types and width helpers for the sequential integer square root.
package isqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int out_w(input int in_w);
    return in_w / 2;
  endfunction

  function automatic int rem_w(input int in_w);
    return (in_w / 2) + 1;
  endfunction

  function automatic int cnt_w(input int in_w);
    return $clog2(in_w / 2) + 1;
  endfunction

endpackage

// File: rtl/isqrt_if.sv
// Valid/ready bundle for isqrt_seq; out_rem exists only when ISQRT_REM_EN is defined.
interface isqrt_if #(
  parameter int IN_W = 8
);
  localparam int OUT_W = isqrt_pkg::out_w(IN_W);
  localparam int REM_W = isqrt_pkg::rem_w(IN_W);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_x;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_root;
`ifdef ISQRT_REM_EN
  logic [REM_W-1:0] out_rem;
`endif
  logic             busy;

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_root,
`ifdef ISQRT_REM_EN
    output out_rem,
`endif
    output busy
  );

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_root,
`ifdef ISQRT_REM_EN
    input  out_rem,
`endif
    input  busy
  );

endinterface

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit iteration: brings in a radicand bit pair, yields one root bit.
module isqrt_step #(
  parameter int OUT_W = 4
) (
  input  logic [OUT_W+1:0] r_i,
  input  logic [OUT_W-1:0] root_i,
  input  logic [1:0]       pair_i,
  output logic [OUT_W+1:0] r_next_o,
  output logic [OUT_W-1:0] root_next_o
);

  logic [OUT_W+1:0] r_sh;
  logic [OUT_W+1:0] trial;
  logic             ge;

  // Partial remainder never exceeds 2*root, so shifting out its top bits loses nothing.
  always_comb begin
    r_sh        = (r_i << 2) | {{OUT_W{1'b0}}, pair_i};
    trial       = {root_i, 2'b01};
    ge          = (r_sh >= trial);
    r_next_o    = ge ? (r_sh - trial) : r_sh;
    root_next_o = (root_i << 1) | OUT_W'(ge);
  end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential floor(sqrt(x)), one root bit per clock; ISQRT_REM_EN adds the registered remainder output.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int IN_W = 8
) (
  input logic    clk,
  input logic    rst_n,
  isqrt_if.slave bus
);

  localparam int OUT_W = out_w(IN_W);
  localparam int REM_W = rem_w(IN_W);
  localparam int CNT_W = cnt_w(IN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_W - 1);

  state_e           state_q, state_d;
  logic [IN_W-1:0]  x_q;
  logic [OUT_W+1:0] r_q;
  logic [OUT_W-1:0] root_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] res_root_q;
`ifdef ISQRT_REM_EN
  logic [REM_W-1:0] res_rem_q;
`endif

  logic [OUT_W+1:0] r_nx;
  logic [OUT_W-1:0] root_nx;
  logic             accept;
  logic             last_iter;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             busy_c;

  assign accept    = (state_q == ST_IDLE) && bus.in_valid;
  assign last_iter = (state_q == ST_CALC) && (cnt_q == LAST_CNT);

  isqrt_step #(.OUT_W(OUT_W)) u_step (
    .r_i         (r_q),
    .root_i      (root_q),
    .pair_i      (x_q[IN_W-1 -: 2]),
    .r_next_o    (r_nx),
    .root_next_o (root_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)        state_d = ST_CALC;
      ST_CALC: if (last_iter)     state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = (state_q == ST_IDLE);
    out_valid_c = (state_q == ST_DONE);
    busy_c      = (state_q == ST_CALC) || (state_q == ST_DONE);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out_root  = res_root_q;
`ifdef ISQRT_REM_EN
  assign bus.out_rem   = res_rem_q;
`endif

  // Working registers advance only in CALC; result registers load on the final iteration
  // and stay frozen through DONE regardless of back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      r_q        <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      res_root_q <= '0;
`ifdef ISQRT_REM_EN
      res_rem_q  <= '0;
`endif
    end else if (accept) begin
      x_q    <= bus.in_x;
      r_q    <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == ST_CALC) begin
      x_q    <= x_q << 2;
      r_q    <= r_nx;
      root_q <= root_nx;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last_iter) begin
        res_root_q <= root_nx;
`ifdef ISQRT_REM_EN
        res_rem_q  <= r_nx[REM_W-1:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq against an arithmetic floor-sqrt model; remainder checks need ISQRT_REM_EN.
module tb_isqrt_seq;

  localparam int IN_W  = 8;
  localparam int OUT_W = IN_W / 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  isqrt_if #(.IN_W(IN_W)) bus ();

  isqrt_seq #(.IN_W(IN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic int ref_root(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents x, waits for the accept edge, then counts edges until out_valid.
  task automatic run_op(input int x, output int lat, output int root, output int rem);
    int g = 0;
    bus.in_x     = IN_W'(x);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && g < 50) begin
      tick();
      g++;
    end
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    root = int'(bus.out_root);
`ifdef ISQRT_REM_EN
    rem = int'(bus.out_rem);
`else
    rem = -1;
`endif
  endtask

  task automatic test_reset();
    bit stray = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.out_ready = 1'b0;
    #12;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.out_root !== '0) begin errors++; $display("FAIL reset_out_root: got %0d expected 0", bus.out_root); end
`ifdef ISQRT_REM_EN
    checks++; if (bus.out_rem !== '0) begin errors++; $display("FAIL reset_out_rem: got %0d expected 0", bus.out_rem); end
`endif
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_x     = 8'd200;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_midcalc_busy: got %b expected 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_async_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_async_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_async_busy: got %b expected 0", bus.busy); end
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) begin
      tick();
      if (bus.out_valid) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL reset_no_stray_result: got %b expected 0", stray); end
  endtask

  task automatic test_latency();
    int lat, root, rem;
    bus.out_ready = 1'b1;
    run_op(255, lat, root, rem);
    checks++; if (lat != OUT_W) begin errors++; $display("FAIL latency_255: got %0d expected %0d", lat, OUT_W); end
    checks++; if (root != 15) begin errors++; $display("FAIL root_255: got %0d expected 15", root); end
`ifdef ISQRT_REM_EN
    checks++; if (rem != 30) begin errors++; $display("FAIL rem_255: got %0d expected 30", rem); end
`endif
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready: got %b expected 0", bus.in_ready); end
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_after_done_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_after_done_out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_values();
    int xs [4] = '{144, 143, 0, 1};
    int lat, root, rem, er;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(xs[i], lat, root, rem);
      er = ref_root(xs[i]);
      checks++; if (root != er) begin errors++; $display("FAIL root_x%0d: got %0d expected %0d", xs[i], root, er); end
`ifdef ISQRT_REM_EN
      checks++; if (rem != xs[i] - er * er) begin errors++; $display("FAIL rem_x%0d: got %0d expected %0d", xs[i], rem, xs[i] - er * er); end
`endif
      checks++; if (lat != OUT_W) begin errors++; $display("FAIL latency_x%0d: got %0d expected %0d", xs[i], lat, OUT_W); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat, root, rem;
    bus.out_ready = 1'b0;
    run_op(50, lat, root, rem);
    for (int c = 0; c < 10; c++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid c%0d: got %b expected 1", c, bus.out_valid); end
      checks++; if (int'(bus.out_root) != ref_root(50)) begin errors++; $display("FAIL bp_root c%0d: got %0d expected %0d", c, bus.out_root, ref_root(50)); end
`ifdef ISQRT_REM_EN
      checks++; if (int'(bus.out_rem) != 1) begin errors++; $display("FAIL bp_rem c%0d: got %0d expected 1", c, bus.out_rem); end
`endif
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b expected 0", c, bus.in_ready); end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_ignore_busy();
    int x0, junk, n, er;
    bit ready_seen = 1'b0;
    x0   = int'($urandom_range(2, 255));
    junk = (x0 ^ 'h5A) & 255;
    er   = ref_root(x0);
    bus.out_ready = 1'b1;
    bus.in_x      = IN_W'(x0);
    bus.in_valid  = 1'b1;
    tick();
    n = 0;
    while (!bus.out_valid && n < 50) begin
      if (bus.in_ready) ready_seen = 1'b1;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_x     = IN_W'(junk);
      tick();
      n++;
    end
    checks++; if (n != OUT_W) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", n, OUT_W); end
    checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL ignore_in_ready_in_calc: got %b expected 0", ready_seen); end
    checks++; if (int'(bus.out_root) != er) begin errors++; $display("FAIL ignore_root x%0d: got %0d expected %0d", x0, bus.out_root, er); end
    bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL no_accept_on_done_edge: got %b expected 1", bus.in_ready); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int xs [6];
    int idx = 0, k = 0, cyc = 0, prev = 0, er, n;
    bit acc;
    for (int i = 0; i < 6; i++) xs[i] = int'($urandom_range(0, 255));
    bus.out_ready = 1'b1;
    bus.in_x      = IN_W'(xs[0]);
    bus.in_valid  = 1'b1;
    while (k < 3 && cyc < 100) begin
      acc = bus.in_ready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        bus.in_x = IN_W'(xs[idx]);
      end
      if (bus.out_valid) begin
        er = ref_root(xs[k]);
        checks++; if (int'(bus.out_root) != er) begin errors++; $display("FAIL b2b_root k%0d: got %0d expected %0d", k, bus.out_root, er); end
        if (k > 0) begin
          checks++; if (cyc - prev != OUT_W + 2) begin errors++; $display("FAIL b2b_spacing k%0d: got %0d expected %0d", k, cyc - prev, OUT_W + 2); end
        end
        prev = cyc;
        k++;
      end
    end
    checks++; if (k != 3) begin errors++; $display("FAIL b2b_result_count: got %0d expected 3", k); end
    bus.in_valid = 1'b0;
    n = 0;
    while (!(bus.in_ready && !bus.out_valid) && n < 50) begin
      tick();
      n++;
    end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_exhaustive();
    int lat, root, rem, n, er;
    bit stable;
    for (int x = 0; x < (1 << IN_W); x++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      run_op(x, lat, root, rem);
      er = ref_root(x);
      checks++; if (lat != OUT_W) begin errors++; $display("FAIL ex_latency x%0d: got %0d expected %0d", x, lat, OUT_W); end
`ifdef ISQRT_REM_EN
      checks++; if (root * root + rem != x || rem > 2 * root) begin errors++; $display("FAIL ex_root_rem x%0d: got root %0d rem %0d expected root %0d rem %0d", x, root, rem, er, x - er * er); end
`else
      checks++; if (root != er) begin errors++; $display("FAIL ex_root x%0d: got %0d expected %0d", x, root, er); end
`endif
      stable = 1'b1;
      n = 0;
      while (bus.out_valid && n < 40) begin
        if (int'(bus.out_root) != root) stable = 1'b0;
`ifdef ISQRT_REM_EN
        if (int'(bus.out_rem) != rem) stable = 1'b0;
`endif
        bus.out_ready = (n >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      checks++; if (stable !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL ex_hold x%0d: got stable %b in_ready %b expected 1 1", x, stable, bus.in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_backpressure();
    test_ignore_busy();
    test_back_to_back();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
